// File: rtl/x_delay_capture_pkg.sv
// Shared types and default sizing for the delay-line capture block.
package x_delay_capture_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StDecode,
        StHold
    } state_e;

    localparam int unsigned DefaultNTaps   = 32;
    localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/x_therm_decode.sv
// Thermometer decoder: bubble-corrects the captured word and counts the
// run of ones starting at the earliest tap.
module x_therm_decode #(
    parameter int unsigned N_TAPS = 32
) (
    input  logic [N_TAPS-1:0]          i_word,
    output logic [$clog2(N_TAPS+1)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int unsigned CountW = $clog2(N_TAPS + 1);

    logic [N_TAPS-1:0] corr;
    logic              run;

    // Majority vote over each interior bit and its two neighbours.
    always_comb begin
        corr = i_word;
        for (int i = 1; i < int'(N_TAPS) - 1; i++) begin
            corr[i] = (i_word[i-1] & i_word[i]) | (i_word[i-1] & i_word[i+1]) |
                      (i_word[i] & i_word[i+1]);
        end
    end

    // Leading-ones count from bit 0; the run stops at the first zero.
    always_comb begin
        o_count = '0;
        run     = 1'b1;
        for (int i = 0; i < int'(N_TAPS); i++) begin
            if (run && corr[i]) begin
                o_count = o_count + CountW'(1);
            end else begin
                run = 1'b0;
            end
        end
        o_overflow = (o_count == CountW'(N_TAPS));
    end

endmodule

// File: rtl/x_delay_capture.sv
// Delay-line capture: synchronises the tap vector, waits for a rising edge
// on tap 0 after arming, captures and decodes the word, then holds the
// result until acknowledged.
module x_delay_capture
    import x_delay_capture_pkg::*;
#(
    parameter int unsigned N_TAPS  = DefaultNTaps,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_arm,
    input  logic [N_TAPS-1:0]           i_taps,
    input  logic                        i_ack,
    output logic                        o_busy,
    output logic                        o_valid,
    output logic [$clog2(N_TAPS+1)-1:0] o_count,
    output logic [N_TAPS-1:0]           o_word,
    output logic                        o_overflow,
    output logic                        o_timeout
);

    localparam int unsigned CountW = $clog2(N_TAPS + 1);
    localparam int unsigned CntW   = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [N_TAPS-1:0]   s1_q, s2_q;
    logic [N_TAPS-1:0]   cap_q, cap_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                prev_q, prev_d;
    logic                valid_q, valid_d;
    logic [CountW-1:0]   count_q, count_d;
    logic [N_TAPS-1:0]   word_q, word_d;
    logic                ovf_q, ovf_d;
    logic                tmo_q, tmo_d;

    logic [CountW-1:0]   dec_count;
    logic                dec_ovf;
    logic                edge_seen;

    x_therm_decode #(
        .N_TAPS(N_TAPS)
    ) u_decode (
        .i_word    (cap_q),
        .o_count   (dec_count),
        .o_overflow(dec_ovf)
    );

    assign edge_seen = s2_q[0] & ~prev_q;

    // Next-state and result-register logic.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        valid_d = valid_q;
        count_d = count_q;
        word_d  = word_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (i_arm) begin
                    state_d = StArmed;
                    cnt_d   = '0;
                    prev_d  = s2_q[0];
                end
            end
            StArmed: begin
                prev_d = s2_q[0];
                cnt_d  = cnt_q + CntW'(1);
                // An edge wins over a timeout landing in the same cycle.
                if (edge_seen) begin
                    state_d = StDecode;
                    cap_d   = s2_q;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    state_d = StHold;
                    valid_d = 1'b1;
                    tmo_d   = 1'b1;
                    ovf_d   = 1'b0;
                    count_d = '0;
                    word_d  = '0;
                end
            end
            StDecode: begin
                state_d = StHold;
                valid_d = 1'b1;
                tmo_d   = 1'b0;
                ovf_d   = dec_ovf;
                count_d = dec_count;
                word_d  = cap_q;
            end
            StHold: begin
                if (i_ack) begin
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    if (i_arm) begin
                        state_d = StArmed;
                        cnt_d   = '0;
                        prev_d  = s2_q[0];
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, synchroniser and result registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            s1_q    <= '0;
            s2_q    <= '0;
            cap_q   <= '0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
            word_q  <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= i_taps;
            s2_q    <= s1_q;
            cap_q   <= cap_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            count_q <= count_d;
            word_q  <= word_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_busy     = (state_q != StIdle);
    assign o_valid    = valid_q;
    assign o_count    = count_q;
    assign o_word     = word_q;
    assign o_overflow = ovf_q;
    assign o_timeout  = tmo_q;

endmodule

// File: tb/tb_x_delay_capture.sv
// Directed bench for x_delay_capture with hand-computed expectations.
module tb_x_delay_capture;

    logic        clk;
    logic        rst;
    logic        arm;
    logic [31:0] taps;
    logic        ack;
    logic        busy;
    logic        valid;
    logic [5:0]  count;
    logic [31:0] word;
    logic        ovf;
    logic        tmo;

    int errors = 0;
    int checks = 0;

    x_delay_capture #(
        .N_TAPS (32),
        .TIMEOUT(255)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_arm     (arm),
        .i_taps    (taps),
        .i_ack     (ack),
        .o_busy    (busy),
        .o_valid   (valid),
        .o_count   (count),
        .o_word    (word),
        .o_overflow(ovf),
        .o_timeout (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // From IDLE with the synchroniser holding 0: enter ARMED, let prev settle.
    task automatic arm_now();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    // From ARMED with tap 0 low: present a word and follow it into HOLD.
    task automatic edge_to_hold(input string tag, input logic [31:0] val);
        taps = val;
        tick(3);
        check({tag, ".decode_valid"}, valid, 0);
        check({tag, ".decode_busy"}, busy, 1);
        tick();
        check({tag, ".valid"}, valid, 1);
    endtask

    task automatic release_hold();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        taps = '0;
        tick(3);
    endtask

    task automatic capture(input string tag, input logic [31:0] val,
                           input logic [5:0] exp_cnt, input logic exp_ovf);
        arm_now();
        edge_to_hold(tag, val);
        check({tag, ".count"}, count, exp_cnt);
        check({tag, ".word"}, word, val);
        check({tag, ".ovf"}, ovf, exp_ovf);
        check({tag, ".tmo"}, tmo, 0);
        release_hold();
    endtask

    initial begin
        rst  = 1'b1;
        arm  = 1'b0;
        ack  = 1'b0;
        taps = '0;
        tick(2);
        check("rst.busy", busy, 0);
        check("rst.valid", valid, 0);
        check("rst.count", count, 0);
        check("rst.word", word, 0);
        check("rst.ovf", ovf, 0);
        check("rst.tmo", tmo, 0);
        rst = 1'b0;
        tick(2);

        // Basic 8-tap edge, then result stability and ack.
        arm_now();
        edge_to_hold("ff", 32'h0000_00FF);
        check("ff.count", count, 8);
        check("ff.word", word, 32'h0000_00FF);
        check("ff.ovf", ovf, 0);
        tick(2);
        check("ff.hold_valid", valid, 1);
        check("ff.hold_count", count, 8);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ff.ack_valid", valid, 0);
        check("ff.ack_busy", busy, 0);
        check("ff.ack_count_kept", count, 8);
        check("ff.ack_word_kept", word, 32'h0000_00FF);
        taps = '0;
        tick(3);

        capture("bubble5", 32'h0000_FFDF, 16, 0);
        capture("all", 32'hFFFF_FFFF, 32, 1);
        capture("low_bubble", 32'h0000_000D, 4, 0);
        capture("single", 32'h0000_0001, 1, 0);

        // Timeout after 255 ARMED cycles.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(254);
        check("tmo.pre_valid", valid, 0);
        check("tmo.pre_busy", busy, 1);
        tick();
        check("tmo.valid", valid, 1);
        check("tmo.tmo", tmo, 1);
        check("tmo.count", count, 0);
        check("tmo.word", word, 0);
        check("tmo.ovf", ovf, 0);
        release_hold();
        check("tmo.cleared", tmo, 0);

        // Edge in the last ARMED cycle beats the timeout.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick(252);
        taps = 32'h0000_000F;
        tick(3);
        check("race.decode_valid", valid, 0);
        check("race.decode_tmo", tmo, 0);
        tick();
        check("race.valid", valid, 1);
        check("race.tmo", tmo, 0);
        check("race.count", count, 4);
        release_hold();

        // Tap 0 already high at arm time is not an edge.
        taps = 32'h0000_0001;
        tick(3);
        arm_now();
        taps = 32'h0000_0003;
        tick(6);
        check("pre_hi.no_valid", valid, 0);
        check("pre_hi.busy", busy, 1);
        taps = '0;
        tick(3);
        edge_to_hold("pre_hi", 32'h0000_0003);
        check("pre_hi.count", count, 2);
        check("pre_hi.word", word, 32'h0000_0003);
        release_hold();

        // Reset while ARMED discards the capture.
        arm_now();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_arm.busy", busy, 0);
        check("rst_arm.count", count, 0);
        check("rst_arm.word", word, 0);
        taps = 32'h0000_000F;
        tick(5);
        check("rst_arm.no_valid", valid, 0);
        check("rst_arm.idle", busy, 0);
        taps = '0;
        tick(3);

        // Reset while HOLD before ack.
        arm_now();
        edge_to_hold("rst_hold", 32'h0000_00FF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_hold.valid", valid, 0);
        check("rst_hold.busy", busy, 0);
        check("rst_hold.count", count, 0);
        check("rst_hold.word", word, 0);
        check("rst_hold.ovf", ovf, 0);
        taps = '0;
        tick(3);

        // Ack with arm held re-arms without an IDLE cycle.
        arm_now();
        edge_to_hold("rearm", 32'h0000_0007);
        check("rearm.count", count, 3);
        ack = 1'b1;
        arm = 1'b1;
        tick();
        ack = 1'b0;
        arm = 1'b0;
        check("rearm.busy", busy, 1);
        check("rearm.valid", valid, 0);
        check("rearm.count_kept", count, 3);
        taps = '0;
        tick(3);
        check("rearm.still_armed", busy, 1);
        edge_to_hold("rearm2", 32'h0000_003F);
        check("rearm2.count", count, 6);
        release_hold();
        check("rearm2.idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/x_delay_capture.md
X_DELAY_CAPTURE -- requirements
Module: x_delay_capture

Interface
REQ-001 Parameter N_TAPS, default 32, SHALL be the number of delay-line taps sampled.
REQ-002 Parameter TIMEOUT, default 255, SHALL be the number of cycles ARMED waits for an edge before aborting.
REQ-003 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 i_arm  input  1  SHALL be a request to start one capture.
REQ-006 i_taps  input  N_TAPS  SHALL be the raw tap vector from the external delay line; bit 0 is the earliest tap; asynchronous to i_clk.
REQ-007 i_ack  input  1  SHALL be the consumer acknowledge of a presented result.
REQ-008 o_busy  output  1  SHALL be high in every state except IDLE.
REQ-009 o_valid  output  1  SHALL be high while a result is presented.
REQ-010 o_count  output  $clog2(N_TAPS+1)  SHALL be the decoded edge position, 0..N_TAPS.
REQ-011 o_word  output  N_TAPS  SHALL be the raw captured tap word.
REQ-012 o_overflow  output  1  SHALL flag that all taps were set.
REQ-013 o_timeout  output  1  SHALL flag that the capture aborted without an edge.

Function
REQ-014 i_taps SHALL pass through two flop stages (s1, s2) every cycle in every state; no logic before s2.
REQ-015 States SHALL be IDLE, ARMED, DECODE, HOLD.
REQ-016 IDLE: i_arm=1 SHALL move to ARMED next cycle; the timeout counter clears to 0.
REQ-017 ARMED: the block SHALL track prev = s2[0] from the previous cycle; s2[0]=1 with prev=0 SHALL latch s2 into the capture register and move to DECODE.
REQ-018 prev SHALL be loaded with the current s2[0] on entry to ARMED, so a tap 0 already high at arm time is not an edge.
REQ-019 ARMED: the counter SHALL increment each cycle; reaching TIMEOUT without an edge SHALL move to HOLD with o_timeout=1, o_count=0, o_word=0.
REQ-020 An edge and the timeout in the same cycle SHALL resolve as an edge.
REQ-021 DECODE SHALL last exactly one cycle and move to HOLD, registering o_count, o_word, o_overflow.
REQ-022 Bubble correction: for 0<i<N_TAPS-1, corrected[i] SHALL be the majority of word[i-1], word[i] and word[i+1]; bits 0 and N_TAPS-1 pass unchanged.
REQ-023 o_count SHALL be the number of consecutive 1s in the corrected word starting at bit 0.
REQ-024 o_overflow SHALL be 1 iff o_count equals N_TAPS.
REQ-025 Latency: o_valid SHALL rise 2 cycles after the edge-detect cycle (capture latch, then DECODE).
REQ-026 HOLD: o_valid=1 and all result outputs SHALL stay stable until i_ack=1.
REQ-027 HOLD with i_ack=1 SHALL go to IDLE, or straight to ARMED if i_arm=1 in the same cycle.
REQ-028 i_arm in ARMED or DECODE SHALL be ignored; i_ack outside HOLD SHALL be ignored.
REQ-029 o_valid, o_overflow and o_timeout SHALL be 0 outside HOLD; o_count and o_word SHALL hold their last values.

Reset
REQ-030 i_rst=1 SHALL force IDLE and clear the counter, s1, s2, prev, the capture register and all outputs to 0 on the next edge, from any state.
REQ-031 Reset mid-capture SHALL discard the capture, with no o_valid afterwards.

Structure
REQ-032 Package x_delay_capture_pkg SHALL hold the state enum and the default N_TAPS and TIMEOUT constants.
REQ-033 Bubble correction and leading-ones count SHALL sit in the combinational sub-module x_therm_decode, parameterised by N_TAPS.

Verification
REQ-034 Arm, then drive taps from 0 to 0x000000FF -> o_valid 2 cycles after edge detect, o_count=8, o_word=0x000000FF, o_overflow=0.
REQ-035 Arm, then taps=0x0000FFDF (bubble at bit 5) -> o_count=16.
REQ-036 Arm, then taps=0xFFFFFFFF -> o_count=32, o_overflow=1.
REQ-037 Arm with taps held at 0 -> after 255 ARMED cycles, o_valid=1, o_timeout=1, o_count=0.
REQ-038 taps already 0x1 at arm time, then 0x3 -> no capture until tap 0 falls and rises again.
REQ-039 Reset asserted in ARMED, then in HOLD before ack -> all outputs 0 and IDLE next cycle; ack with arm held -> re-enters ARMED with no IDLE cycle.
